clk_enable_gen: RTL and testbench

Parametrised multi-channel fractional clock-enable generator running entirely in the sys_clk domain. Each channel produces single-cycle enable strobes at an average rate of sys_clk × NUM/DEN, plus a derived toggle clock. Its default of 63/250 gives 25.2 MHz from 100 MHz. Channels are reprogrammable at runtime through a valid/ready config port. Each channel has a per-channel "ready" that mimics PLL lock after settling. It replaces dedicated divided clocks for low-rate peripherals (pixel, UART, PS/2 timing) with clock enables.

---
 rtl/clk_enable_gen_pkg.sv | 33 +++
 rtl/clk_enable_gen_chan.sv | 87 ++++++++
 rtl/clk_enable_gen.sv | 93 +++++++++
 tb/tb_clk_enable_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_enable_gen_pkg.sv
// Shared types for the fractional clock-enable generator.
// Holds channel/config FSM encodings, a config request struct and the request validity rule.
// No logic of its own; imported by the channel and top modules.
package clk_enable_gen_pkg;

  localparam int CLK_GEN_ACC_W  = 16;
  localparam int CLK_GEN_CHAN_W = 1;

  typedef struct packed {
    logic [CLK_GEN_CHAN_W-1:0] chan;
    logic [CLK_GEN_ACC_W-1:0]  num;
    logic [CLK_GEN_ACC_W-1:0]  den;
  } clk_gen_cfg_t;

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } clk_chan_state_t;

  typedef enum logic {
    CFG_IDLE  = 1'b0,
    CFG_APPLY = 1'b1
  } clk_cfg_state_t;

  // A request is usable only with a nonzero denominator, num <= den and an existing channel.
  function automatic logic cfg_req_ok(input logic [31:0] chan,
                                      input logic [31:0] num,
                                      input logic [31:0] den,
                                      input logic [31:0] channels);
    return (den != 32'd0) && (num <= den) && (chan < channels);
  endfunction

endpackage

// File: rtl/clk_enable_gen_chan.sv
// One fractional enable channel: settle counter, then phase accumulator producing num strobes per den cycles.
// Latency: strobes/clock/ready are registered; a load takes effect on the next edge.
// No backpressure; i_load overrides everything and restarts the settle period.
module clk_enable_chan
  import clk_enable_gen_pkg::*;
#(
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int RESET_NUM   = 63,
  parameter int RESET_DEN   = 250
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [ACC_W-1:0] i_num,
  input  logic [ACC_W-1:0] i_den,
  output logic             o_en,
  output logic             o_clk,
  output logic             o_ready
);

  localparam int                LOCK_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  clk_chan_state_t   r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_num;
  logic [ACC_W-1:0]  r_den;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic              r_en;
  logic              r_clk;
  logic              r_ready;

  logic [ACC_W:0]    w_sum;
  logic              w_hit;
  logic [ACC_W-1:0]  w_rem;

  // One extra bit so acc + num never wraps before the compare against den.
  assign w_sum = {1'b0, r_acc} + {1'b0, r_num};
  assign w_hit = (w_sum >= {1'b0, r_den});
  assign w_rem = ACC_W'(w_sum - {1'b0, r_den});

  // Channel FSM: load restarts settling, SETTLE counts to lock, RUN accumulates and strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= SETTLE;
      r_acc      <= '0;
      r_num      <= ACC_W'(RESET_NUM);
      r_den      <= ACC_W'(RESET_DEN);
      r_lock_cnt <= '0;
      r_en       <= 1'b0;
      r_clk      <= 1'b0;
      r_ready    <= 1'b0;
    end else if (i_load) begin
      r_state    <= SETTLE;
      r_acc      <= '0;
      r_num      <= i_num;
      r_den      <= i_den;
      r_lock_cnt <= '0;
      r_en       <= 1'b0;
      r_clk      <= 1'b0;
      r_ready    <= 1'b0;
    end else if (r_state == SETTLE) begin
      r_acc      <= '0;
      r_en       <= 1'b0;
      r_lock_cnt <= r_lock_cnt + 1'b1;
      if (r_lock_cnt == LOCK_LAST) begin
        r_ready <= 1'b1;
        r_state <= RUN;
      end
    end else begin
      if (w_hit) begin
        r_acc <= w_rem;
        r_en  <= 1'b1;
        r_clk <= ~r_clk;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
        r_en  <= 1'b0;
      end
    end
  end

  assign o_en    = r_en;
  assign o_clk   = r_clk;
  assign o_ready = r_ready;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator with a runtime valid/ready config port.
// Latency: request accepted on one edge, applied (or rejected via cfg_err_o) on the next.
// Backpressure: cfg_ready_o drops for the single APPLY cycle, giving one request per 2 cycles.
module clk_enable_gen
  import clk_enable_gen_pkg::*;
#(
  parameter int  CHANNELS    = 2,
  parameter int  ACC_W       = 16,
  parameter int  LOCK_CYCLES = 16,
  parameter int  RESET_NUM   = 63,
  parameter int  RESET_DEN   = 250,
  localparam int CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                sys_clk_i,
  input  logic                reset_async_ni,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [CHAN_W-1:0]   cfg_chan_i,
  input  logic [ACC_W-1:0]    cfg_num_i,
  input  logic [ACC_W-1:0]    cfg_den_i,
  output logic                cfg_err_o,
  output logic [CHANNELS-1:0] en_o,
  output logic [CHANNELS-1:0] clk_o,
  output logic [CHANNELS-1:0] ready_o
);

  clk_cfg_state_t     r_cfg_state;
  logic               r_cfg_ready;
  logic               r_cfg_err;
  logic [CHAN_W-1:0]  r_chan;
  logic [ACC_W-1:0]   r_num;
  logic [ACC_W-1:0]   r_den;

  logic               w_req_ok;
  logic               w_apply;

  assign w_req_ok = cfg_req_ok(32'(r_chan), 32'(r_num), 32'(r_den), 32'(CHANNELS));
  assign w_apply  = (r_cfg_state == CFG_APPLY) && w_req_ok;

  // Config FSM: latch a request in IDLE, validate and report in APPLY, then return to IDLE.
  always_ff @(posedge sys_clk_i or negedge reset_async_ni) begin
    if (!reset_async_ni) begin
      r_cfg_state <= CFG_IDLE;
      r_cfg_ready <= 1'b1;
      r_cfg_err   <= 1'b0;
      r_chan      <= '0;
      r_num       <= '0;
      r_den       <= '0;
    end else begin
      r_cfg_err <= 1'b0;
      if (r_cfg_state == CFG_IDLE) begin
        if (cfg_valid_i && r_cfg_ready) begin
          r_chan      <= cfg_chan_i;
          r_num       <= cfg_num_i;
          r_den       <= cfg_den_i;
          r_cfg_ready <= 1'b0;
          r_cfg_state <= CFG_APPLY;
        end
      end else begin
        r_cfg_err   <= ~w_req_ok;
        r_cfg_ready <= 1'b1;
        r_cfg_state <= CFG_IDLE;
      end
    end
  end

  assign cfg_ready_o = r_cfg_ready;
  assign cfg_err_o   = r_cfg_err;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic w_load;

    // Only the addressed channel sees the load; the others keep running untouched.
    assign w_load = w_apply && (r_chan == CHAN_W'(g));

    clk_enable_chan #(
      .ACC_W       (ACC_W),
      .LOCK_CYCLES (LOCK_CYCLES),
      .RESET_NUM   (RESET_NUM),
      .RESET_DEN   (RESET_DEN)
    ) u_chan (
      .i_clk   (sys_clk_i),
      .i_rst_n (reset_async_ni),
      .i_load  (w_load),
      .i_num   (r_num),
      .i_den   (r_den),
      .o_en    (en_o[g]),
      .o_clk   (clk_o[g]),
      .o_ready (ready_o[g])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen against a closed-form reference model.
// Three channels are used so that channel index 3 is representable on the port yet out of range.
module tb_clk_enable_gen;

  localparam int NCH = 3;
  localparam int AW  = 16;
  localparam int CW  = 2;
  localparam int LC  = 16;
  localparam int RN  = 63;
  localparam int RD  = 250;

  logic           sys_clk = 1'b0;
  logic           rst_n   = 1'b1;
  logic           cfg_valid = 1'b0;
  logic [CW-1:0]  cfg_chan  = '0;
  logic [AW-1:0]  cfg_num   = '0;
  logic [AW-1:0]  cfg_den   = '0;
  logic           cfg_ready;
  logic           cfg_err;
  logic [NCH-1:0] en;
  logic [NCH-1:0] clko;
  logic [NCH-1:0] rdy;

  clk_enable_gen #(
    .CHANNELS    (NCH),
    .ACC_W       (AW),
    .LOCK_CYCLES (LC),
    .RESET_NUM   (RN),
    .RESET_DEN   (RD)
  ) dut (
    .sys_clk_i      (sys_clk),
    .reset_async_ni (rst_n),
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready),
    .cfg_chan_i     (cfg_chan),
    .cfg_num_i      (cfg_num),
    .cfg_den_i      (cfg_den),
    .cfg_err_o      (cfg_err),
    .en_o           (en),
    .clk_o          (clko),
    .ready_o        (rdy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each channel is described by edges since its last load/reset (m_t)
  // and its ratio; strobes follow floor(k*num/den) over RUN cycles k.
  longint      m_t   [NCH];
  longint      m_num [NCH];
  longint      m_den [NCH];
  bit          m_busy;
  bit          m_err;
  bit          m_took;
  int unsigned m_rc, m_rn, m_rd;

  function automatic longint strobes_upto(int c, longint k);
    return (k * m_num[c]) / m_den[c];
  endfunction

  function automatic bit exp_en(int c);
    longint k;
    if (m_t[c] <= LC) return 1'b0;
    k = m_t[c] - LC;
    return strobes_upto(c, k) != strobes_upto(c, k - 1);
  endfunction

  function automatic bit exp_clk(int c);
    if (m_t[c] <= LC) return 1'b0;
    return strobes_upto(c, m_t[c] - LC) % 2 == 1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_t[c]   = 0;
      m_num[c] = RN;
      m_den[c] = RD;
    end
    m_busy = 1'b0;
    m_err  = 1'b0;
    m_took = 1'b0;
  endtask

  task automatic model_edge();
    bit do_load;
    m_err   = 1'b0;
    m_took  = 1'b0;
    do_load = 1'b0;
    if (m_busy) begin
      m_busy = 1'b0;
      if (m_rd == 0 || m_rn > m_rd || m_rc >= NCH) m_err = 1'b1;
      else do_load = 1'b1;
    end else if (cfg_valid) begin
      m_rc   = cfg_chan;
      m_rn   = cfg_num;
      m_rd   = cfg_den;
      m_busy = 1'b1;
      m_took = 1'b1;
    end
    for (int c = 0; c < NCH; c++) begin
      if (do_load && c == int'(m_rc)) begin
        m_t[c]   = 0;
        m_num[c] = m_rn;
        m_den[c] = m_rd;
      end else begin
        m_t[c]++;
      end
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0] e_en, e_clk, e_rdy;
    for (int c = 0; c < NCH; c++) begin
      e_en[c]  = exp_en(c);
      e_clk[c] = exp_clk(c);
      e_rdy[c] = (m_t[c] >= LC);
    end
    check("en_o",        32'(en),        32'(e_en));
    check("clk_o",       32'(clko),      32'(e_clk));
    check("ready_o",     32'(rdy),       32'(e_rdy));
    check("cfg_ready_o", 32'(cfg_ready), 32'(!m_busy));
    check("cfg_err_o",   32'(cfg_err),   32'(m_err));
  endtask

  task automatic step();
    @(posedge sys_clk);
    if (rst_n) model_edge();
    #2;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input int ch, input int num, input int den, input bit keep);
    cfg_valid = 1'b1;
    cfg_chan  = CW'(ch);
    cfg_num   = AW'(num);
    cfg_den   = AW'(den);
    for (int i = 0; i < 8; i++) begin
      step();
      if (m_took) break;
    end
    if (!keep) cfg_valid = 1'b0;
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock edge.
  task automatic async_reset(input int hold);
    #1 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    run(hold);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1 compare_all();
    run(3);
    #1 rst_n = 1'b1;

    // Defaults after reset release.
    run(600);

    // ch0 to 1/1: strobe every cycle after settling.
    send(0, 1, 1, 1'b0);
    run(60);

    // ch1 to 1/4, then reprogram mid-settle to 3/4.
    send(1, 1, 4, 1'b0);
    run(6);
    send(1, 3, 4, 1'b0);
    run(60);

    // Rejected requests: zero denominator, num > den, channel out of range.
    send(0, 0, 0, 1'b0);
    run(3);
    send(1, 5, 3, 1'b0);
    run(3);
    send(3, 1, 2, 1'b0);
    run(30);

    // Valid held high across two different requests.
    send(2, 1, 3, 1'b1);
    send(2, 2, 5, 1'b0);
    run(60);

    // Randomized requests, some invalid, held until accepted.
    for (int i = 0; i < 3000; i++) begin
      if (m_took || !cfg_valid) begin
        cfg_valid = ($urandom_range(0, 39) == 0);
        cfg_chan  = CW'($urandom_range(0, 3));
        cfg_den   = AW'($urandom_range(0, 12));
        cfg_num   = AW'($urandom_range(0, 14));
      end
      step();
    end
    cfg_valid = 1'b0;
    run(50);

    // Asynchronous reset mid-run, then defaults again.
    async_reset(2);
    run(600);

    // Reset landing in the APPLY cycle discards the request.
    send(0, 1, 2, 1'b0);
    async_reset(1);
    run(300);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
